vga_sync_monitor: RTL and testbench



---
 rtl/vga_sync_monitor.sv | 206 ++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// VGA receive-side timing monitor: recovers pixel coordinates and colour, checks line/frame
// periods and tracks lock. Define VGA_CRC_EN to build the per-frame CRC-16 of visible pixels.
module vga_sync_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_START     = 44,
    parameter int unsigned V_START     = 30,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [3:0]  R,
    input  logic [3:0]  G,
    input  logic [3:0]  B,
    output logic        locked,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic [7:0]  err_cnt,
    output logic [15:0] frame_crc,
    output logic        crc_valid
);
    localparam int unsigned HW = 11;
    localparam int unsigned VW = 10;
    localparam int unsigned GW = 8;
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_LO   = HW'(H_START);
    localparam logic [HW-1:0] H_HI   = HW'(H_START + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_LO   = VW'(V_START);
    localparam logic [VW-1:0] V_HI   = VW'(V_START + V_ACTIVE);
    localparam logic [GW-1:0] G_LAST = GW'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    logic          r_hs_q, r_vs_q, r_vs_pend;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    state_t        r_state, w_state_nxt;
    logic [GW-1:0] r_good, w_good_nxt;

    logic          w_h_rise, w_v_rise, w_realign, w_line_bad, w_frame_bad;
    logic [HW-1:0] w_hcnt_nxt;
    logic [VW-1:0] w_vcnt_nxt;
    logic          w_pix_valid_nxt, w_locked_nxt, w_err_inc;

    // Edge detection and counter next values; every event is qualified by pix_en.
    always_comb begin
        w_h_rise    = pix_en & ~r_hs_q & hsync;
        w_v_rise    = pix_en & ~r_vs_q & vsync;
        w_realign   = w_h_rise & (r_vs_pend | w_v_rise);
        w_line_bad  = w_h_rise & (r_hcnt != H_LAST);
        w_frame_bad = w_realign & (r_vcnt != V_LAST);
        w_hcnt_nxt  = (r_hcnt == '1) ? r_hcnt : r_hcnt + HW'(1);
        w_vcnt_nxt  = r_vcnt;
        if (w_h_rise) begin
            w_hcnt_nxt = '0;
        end
        if (w_realign) begin
            w_vcnt_nxt = '0;
        end else if (w_h_rise && r_vcnt != '1) begin
            w_vcnt_nxt = r_vcnt + VW'(1);
        end
        w_pix_valid_nxt = pix_en & locked
                        & (w_hcnt_nxt >= H_LO) & (w_hcnt_nxt < H_HI)
                        & (w_vcnt_nxt >= V_LO) & (w_vcnt_nxt < V_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs_q    <= 1'b0;
            r_vs_q    <= 1'b0;
            r_vs_pend <= 1'b0;
            r_hcnt    <= '0;
            r_vcnt    <= '0;
        end else if (pix_en) begin
            r_hs_q    <= hsync;
            r_vs_q    <= vsync;
            r_vs_pend <= w_realign ? 1'b0 : (r_vs_pend | w_v_rise);
            r_hcnt    <= w_hcnt_nxt;
            r_vcnt    <= w_vcnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEARCH;
            r_good  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_good  <= w_good_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        case (r_state)
            SEARCH: begin
                if (w_realign) begin
                    w_state_nxt = ACQUIRE;
                    w_good_nxt  = '0;
                end
            end
            ACQUIRE: begin
                if (w_line_bad || w_frame_bad) begin
                    w_good_nxt = '0;
                end else if (w_realign) begin
                    w_good_nxt = r_good + GW'(1);
                    if (r_good >= G_LAST) begin
                        w_state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_line_bad || w_frame_bad) begin
                    w_state_nxt = SEARCH;
                    w_good_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = SEARCH;
                w_good_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        w_locked_nxt = (w_state_nxt == LOCKED);
        w_err_inc    = (r_state == LOCKED) && (w_state_nxt == SEARCH);
    end

    // Status and pixel outputs; strobes are cleared on every non-tick clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked      <= 1'b0;
            err_cnt     <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (pix_en) begin
                locked      <= w_locked_nxt;
                pix_valid   <= w_pix_valid_nxt;
                pix_x       <= 10'(w_hcnt_nxt - H_LO);
                pix_y       <= 10'(w_vcnt_nxt - V_LO);
                pix_rgb     <= {R, G, B};
                frame_start <= w_realign;
                if (w_err_inc && err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end

`ifdef VGA_CRC_EN
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                 c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [15:0] r_crc_run;

    // Running CRC restarts at every re-alignment; it is published only while locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crc_run <= 16'hFFFF;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            if (pix_en) begin
                if (w_realign) begin
                    if (locked) begin
                        frame_crc <= r_crc_run;
                        crc_valid <= 1'b1;
                    end
                    r_crc_run <= 16'hFFFF;
                end else if (w_pix_valid_nxt) begin
                    r_crc_run <= crc16_step(r_crc_run, {4'h0, R, G, B});
                end
            end
        end
    end
`else
    assign frame_crc = '0;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor on a reduced 40x12 raster (16x6 visible).
module tb_vga_sync_monitor;
    localparam int HT  = 40;
    localparam int VT  = 12;
    localparam int HA  = 16;
    localparam int VA  = 6;
    localparam int HS0 = 8;
    localparam int VS0 = 3;
    localparam int HSL = 5;

    logic        clk = 1'b0, rst_n = 1'b1, pix_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [3:0]  R = '0, G = '0, B = '0;
    logic        locked, pix_valid, frame_start, crc_valid;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic [7:0]  err_cnt;
    logic [15:0] frame_crc;

    vga_sync_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_START(HS0), .V_START(VS0), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .R(R), .G(G), .B(B), .locked(locked), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb), .frame_start(frame_start),
        .err_cnt(err_cnt), .frame_crc(frame_crc), .crc_valid(crc_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } pix_t;

    typedef struct {
        logic        lk;
        logic [7:0]  err;
        int          cnt;
        logic        crc_v;
        logic [15:0] crc;
    } frm_t;

    pix_t pix_q[$];
    frm_t frm_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   tick_no  = 0;
    int   pcnt     = 0;
    logic exp_locked = 1'b0;
    logic [15:0] crc_run = 16'hFFFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [15:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic tick(input logic hs, input logic vs, input logic [11:0] rgb);
        @(negedge clk);
        hsync = hs; vsync = vs; {R, G, B} = rgb; pix_en = 1'b1;
        tick_no++;
        if (tick_no % 3 == 0) begin
            @(negedge clk);
            pix_en = 1'b0;
        end
    endtask

    // Non-tick clocks with junk on the sync/colour lines; nothing may move.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix_en = 1'b0; hsync = i[0]; vsync = ~i[0]; {R, G, B} = 12'hABC;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_locked",      32'(locked),      32'h0);
        check("rst_pix_valid",   32'(pix_valid),   32'h0);
        check("rst_pix_x",       32'(pix_x),       32'h0);
        check("rst_pix_y",       32'(pix_y),       32'h0);
        check("rst_pix_rgb",     32'(pix_rgb),     32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("rst_err_cnt",     32'(err_cnt),     32'h0);
        check("rst_frame_crc",   32'(frame_crc),   32'h0);
        check("rst_crc_valid",   32'(crc_valid),   32'h0);
    endtask

    // lk/err: expected locked and err_cnt right after the re-alignment that opens this frame.
    task automatic run_frame(input logic lk, input logic [7:0] err, input int bad_v, input int bad_len,
                             input logic mark, input int stop_v, input int stop_k);
        int          len, kc;
        logic [11:0] rgb;
        frm_t        f;
        for (int v = 0; v < VT; v++) begin
            len = (v == bad_v) ? bad_len : HT;
            for (int k = 0; k < len; k++) begin
                if (v == stop_v && k == stop_k) return;
                if (k == 0 && v == 0) begin
                    f.lk = lk; f.err = err; f.cnt = pcnt; f.crc_v = exp_locked; f.crc = crc_run;
                    frm_q.push_back(f);
                    pcnt = 0; crc_run = 16'hFFFF; exp_locked = lk;
                end
                if (bad_v >= 0 && k == 0 && v == bad_v + 1) exp_locked = 1'b0;
                if (mark) rgb = (k == HS0 && v == VS0) ? 12'hF00 : 12'h000;
                else      rgb = 12'((k * 37) + (v * 101) + 5);
                kc = (k > 2047) ? 2047 : k;
                if (exp_locked && kc >= HS0 && kc < HS0 + HA && v >= VS0 && v < VS0 + VA) begin
                    pix_q.push_back('{x: 10'(kc - HS0), y: 10'(v - VS0), rgb: rgb});
                    pcnt++;
                    crc_run = crc_ref(crc_run, {4'h0, rgb});
                end
                tick(!(k >= len - HSL), !(v >= VT - 2), rgb);
                if (bad_v >= 0 && k == 0 && v == bad_v + 1) begin
                    @(posedge clk); #1;
                    check("lock_lost_on_bad_line", 32'(locked), 32'h0);
                    check("err_cnt_after_bad_line", 32'(err_cnt), 32'(err + 8'd1));
                end
                if (v == 4 && k == 12) idle(8);
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel or a frame start.
    initial begin
        pix_t pe;
        frm_t fe;
        int   mon_cnt;
        mon_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                mon_cnt = 0;
            end else begin
                if (pix_valid) begin
                    mon_cnt++;
                    if (pix_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_pixel: got x=%0d y=%0d rgb=0x%0h, expected none",
                                 pix_x, pix_y, pix_rgb);
                    end else begin
                        pe = pix_q.pop_front();
                        check("pix_x",   32'(pix_x),   32'(pe.x));
                        check("pix_y",   32'(pix_y),   32'(pe.y));
                        check("pix_rgb", 32'(pix_rgb), 32'(pe.rgb));
                    end
                end
                if (frame_start) begin
                    if (frm_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_frame_start: got 1, expected 0");
                    end else begin
                        fe = frm_q.pop_front();
                        check("frame_locked",  32'(locked),  32'(fe.lk));
                        check("frame_err_cnt", 32'(err_cnt), 32'(fe.err));
                        check("frame_pix_cnt", 32'(mon_cnt), 32'(fe.cnt));
`ifdef VGA_CRC_EN
                        check("crc_valid", 32'(crc_valid), 32'(fe.crc_v));
                        if (fe.crc_v) check("frame_crc", 32'(frame_crc), 32'(fe.crc));
`else
                        check("crc_valid_off", 32'(crc_valid), 32'h0);
                        check("frame_crc_off", 32'(frame_crc), 32'h0);
`endif
                    end
                    mon_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        #3 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Acquisition: realign -> ACQUIRE, two good frames -> LOCKED.
        run_frame(1'b0, 8'd0, -1, HT, 1'b0, -1, -1);
        run_frame(1'b0, 8'd0, -1, HT, 1'b0, -1, -1);
        run_frame(1'b1, 8'd0, -1, HT, 1'b1, -1, -1);
        // Short line (39 ticks) at row 5, then re-acquisition.
        run_frame(1'b1, 8'd0, 5, HT - 1, 1'b0, -1, -1);
        run_frame(1'b0, 8'd1, -1, HT, 1'b0, -1, -1);
        run_frame(1'b0, 8'd1, -1, HT, 1'b0, -1, -1);
        // 2088-tick line: a wrapping 11-bit counter would land exactly on H_TOTAL-1.
        run_frame(1'b1, 8'd1, 4, 2088, 1'b0, -1, -1);
        run_frame(1'b0, 8'd2, -1, HT, 1'b0, -1, -1);
        run_frame(1'b0, 8'd2, -1, HT, 1'b0, -1, -1);
        run_frame(1'b1, 8'd2, -1, HT, 1'b0, 4, 12);

        // Asynchronous reset mid-line while locked.
        @(negedge clk);
        pix_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        check("queue_empty_at_reset", 32'(pix_q.size()), 32'h0);
        pix_q.delete(); frm_q.delete();
        pcnt = 0; exp_locked = 1'b0; crc_run = 16'hFFFF;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        run_frame(1'b0, 8'd0, -1, HT, 1'b0, -1, -1);
        run_frame(1'b0, 8'd0, -1, HT, 1'b0, -1, -1);
        run_frame(1'b1, 8'd0, -1, HT, 1'b0, -1, -1);
        run_frame(1'b1, 8'd0, -1, HT, 1'b0, 0, 1);
        idle(10);

        check("pix_queue_drained",   32'(pix_q.size()), 32'h0);
        check("frame_queue_drained", 32'(frm_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
